// File: rtl/cache_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cache_pkg
//  Description : Shared widths, line record type and tag-width helper for the
//                direct-mapped write-through cache.
//  Revision    : 1.0 - initial release
// ============================================================================
package cache_pkg;

    localparam int ADDR_W   = 32;
    localparam int DATA_W   = 32;
    localparam int OFFSET_W = 2;

    // Widest tag possible (index of at least one bit). Narrower tags are
    // zero-extended into this field so one record type serves every size.
    localparam int MAX_TAG_W = ADDR_W - OFFSET_W - 1;

    typedef struct packed {
        logic                 valid;
        logic [MAX_TAG_W-1:0] tag;
        logic [DATA_W-1:0]    data;
    } line_t;

    function automatic int tag_width(input int index_w);
        return ADDR_W - OFFSET_W - index_w;
    endfunction

endpackage
`default_nettype wire

// File: rtl/wt_backing_mem.sv
`default_nettype none
// ============================================================================
//  Module      : wt_backing_mem
//  Description : Word-addressed backing store standing in for main memory.
//                Synchronous write, asynchronous read, no reset.
//  Ports       : clk      - rising-edge clock
//                i_we     - write enable
//                i_addr   - word address
//                i_wdata  - write data
//                o_rdata  - combinational read data at i_addr
//  Revision    : 1.0 - initial release
// ============================================================================
module wt_backing_mem
    import cache_pkg::*;
#(
    parameter int MEM_DEPTH = 4096,
    parameter int MEM_W     = $clog2(MEM_DEPTH)
) (
    input  logic              clk,
    input  logic              i_we,
    input  logic [MEM_W-1:0]  i_addr,
    input  logic [DATA_W-1:0] i_wdata,
    output logic [DATA_W-1:0] o_rdata
);

    logic [DATA_W-1:0] r_mem [MEM_DEPTH];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_addr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_addr];

endmodule
`default_nettype wire

// File: rtl/direct_mapped_wt_cache.sv
`default_nettype none
// ============================================================================
//  Module      : direct_mapped_wt_cache
//  Description : Direct-mapped, write-through, write-allocate data cache with
//                one 32-bit word per line and an internal backing memory.
//                One request per clock, result registered one cycle later.
//  Ports       : clk        - rising-edge clock
//                reset      - asynchronous active-high reset
//                address    - byte address of the request (sampled each edge)
//                is_write   - 1 = write, 0 = read
//                write_data - write data (ignored on reads)
//                hit        - registered hit flag for last sampled request
//                read_data  - registered data word for last sampled request
//                hit_count  - (DIRECT_MAPPED_WT_STATS_EN) requests that hit
//                miss_count - (DIRECT_MAPPED_WT_STATS_EN) requests that missed
//  Options     : `define DIRECT_MAPPED_WT_STATS_EN to add hit/miss counters.
//  Revision    : 1.0 - initial release
// ============================================================================
module direct_mapped_wt_cache
    import cache_pkg::*;
#(
    parameter int    CACHE_SIZE = 64,
    parameter string WRITING    = "write_through",
    parameter int    MEM_DEPTH  = 4096
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] address,
    input  logic              is_write,
    input  logic [DATA_W-1:0] write_data,
    output logic              hit,
    output logic [DATA_W-1:0] read_data
`ifdef DIRECT_MAPPED_WT_STATS_EN
    ,
    output logic [31:0]       hit_count,
    output logic [31:0]       miss_count
`endif
);

    localparam int INDEX_W = $clog2(CACHE_SIZE);
    localparam int TAG_W   = tag_width(INDEX_W);
    localparam int MEM_W   = $clog2(MEM_DEPTH);

    generate
        if (WRITING != "write_through") begin : g_bad_policy
            $error("direct_mapped_wt_cache: only write_through is supported");
        end
        if (CACHE_SIZE < 2 || (1 << INDEX_W) != CACHE_SIZE) begin : g_bad_size
            $error("direct_mapped_wt_cache: CACHE_SIZE must be a power of two >= 2");
        end
        if ((1 << MEM_W) != MEM_DEPTH) begin : g_bad_depth
            $error("direct_mapped_wt_cache: MEM_DEPTH must be a power of two");
        end
    endgenerate

    // ------------------------------------------------------------------
    // Address decode
    // ------------------------------------------------------------------
    logic [INDEX_W-1:0] w_index;
    logic [TAG_W-1:0]   w_tag;
    logic [MEM_W-1:0]   w_mem_addr;
    logic               w_unused_offset;

    assign w_index         = address[OFFSET_W +: INDEX_W];
    assign w_tag           = address[ADDR_W-1 -: TAG_W];
    assign w_mem_addr      = address[OFFSET_W +: MEM_W];
    // Word access only: the byte offset carries no information.
    assign w_unused_offset = ^address[OFFSET_W-1:0];

    // ------------------------------------------------------------------
    // Line storage: valid bits are reset, tag/data arrays are not
    // ------------------------------------------------------------------
    logic [CACHE_SIZE-1:0] r_valid;
    logic [TAG_W-1:0]      r_tag  [CACHE_SIZE];
    logic [DATA_W-1:0]     r_data [CACHE_SIZE];

    line_t             w_line;
    logic              w_match;
    logic [DATA_W-1:0] w_mem_rdata;
    logic [DATA_W-1:0] w_fill;
    logic              w_mem_we;

    assign w_line = '{valid: r_valid[w_index],
                      tag:   MAX_TAG_W'(r_tag[w_index]),
                      data:  r_data[w_index]};

    assign w_match = w_line.valid && (w_line.tag == MAX_TAG_W'(w_tag));

    // The value the line holds after this request is also the value
    // returned: write data, the hit data, or the backing word on a miss.
    assign w_fill = is_write ? write_data
                  : (w_match ? w_line.data : w_mem_rdata);

    // Requests sampled during reset are dropped, so no backing write either.
    assign w_mem_we = is_write && !reset;

    wt_backing_mem #(
        .MEM_DEPTH (MEM_DEPTH),
        .MEM_W     (MEM_W)
    ) u_backing_mem (
        .clk     (clk),
        .i_we    (w_mem_we),
        .i_addr  (w_mem_addr),
        .i_wdata (write_data),
        .o_rdata (w_mem_rdata)
    );

    // ------------------------------------------------------------------
    // Registered response and valid bits
    // ------------------------------------------------------------------
    logic              r_hit;
    logic [DATA_W-1:0] r_read_data;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_valid     <= '0;
            r_hit       <= 1'b0;
            r_read_data <= '0;
        end else begin
            r_valid[w_index] <= 1'b1;
            r_hit            <= w_match;
            r_read_data      <= w_fill;
        end
    end

    // Every processed request (re)allocates its line; rewriting a hit line
    // with its own data is harmless and keeps the write path uniform.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_tag[w_index]  <= w_tag;
            r_data[w_index] <= w_fill;
        end
    end

    assign hit       = r_hit;
    assign read_data = r_read_data;

`ifdef DIRECT_MAPPED_WT_STATS_EN
    logic [31:0] r_hit_count;
    logic [31:0] r_miss_count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_hit_count  <= '0;
            r_miss_count <= '0;
        end else if (w_match) begin
            r_hit_count  <= r_hit_count + 32'd1;
        end else begin
            r_miss_count <= r_miss_count + 32'd1;
        end
    end

    assign hit_count  = r_hit_count;
    assign miss_count = r_miss_count;
`endif

endmodule
`default_nettype wire

// File: tb/tb_direct_mapped_wt_cache.sv
`default_nettype none
// ============================================================================
//  Module      : tb_direct_mapped_wt_cache
//  Description : Scoreboard bench for direct_mapped_wt_cache. A reference
//                model predicts each response when the request is driven;
//                a monitor compares the registered outputs one cycle later.
//  Options     : honours `define DIRECT_MAPPED_WT_STATS_EN
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_direct_mapped_wt_cache;

    localparam int CS = 64;
    localparam int MD = 4096;

    logic        clk;
    logic        reset;
    logic [31:0] address;
    logic        is_write;
    logic [31:0] write_data;
    logic        hit;
    logic [31:0] read_data;
`ifdef DIRECT_MAPPED_WT_STATS_EN
    logic [31:0] hit_count;
    logic [31:0] miss_count;
`endif

    direct_mapped_wt_cache dut (
        .clk        (clk),
        .reset      (reset),
        .address    (address),
        .is_write   (is_write),
        .write_data (write_data),
        .hit        (hit),
        .read_data  (read_data)
`ifdef DIRECT_MAPPED_WT_STATS_EN
        ,
        .hit_count  (hit_count),
        .miss_count (miss_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    // ------------------------------------------------------------------
    // Reference model: cache lines and a sparse backing memory
    // ------------------------------------------------------------------
    bit          m_valid [CS];
    int unsigned m_tag   [CS];
    logic [31:0] m_data  [CS];
    bit          m_known [CS];
    logic [31:0] m_mem   [int];
    int unsigned m_hc = 0;
    int unsigned m_mc = 0;

    typedef struct {
        logic [31:0] addr;
        bit          hit;
        bit          known;
        logic [31:0] data;
        int unsigned cyc;
        int unsigned hc;
        int unsigned mc;
    } exp_t;

    exp_t sb[$];

    task automatic model_reset();
        for (int i = 0; i < CS; i++) m_valid[i] = 1'b0;
        m_hc = 0;
        m_mc = 0;
    endtask

    task automatic do_req(input logic [31:0] a, input bit w, input logic [31:0] d);
        int unsigned idx, tg, mw;
        bit          match;
        exp_t        e;
        idx   = (a >> 2) % CS;
        tg    = a >> (2 + $clog2(CS));
        mw    = (a >> 2) % MD;
        match = m_valid[idx] && (m_tag[idx] == tg);
        e.addr = a;
        e.hit  = match;
        if (w) begin
            e.known  = 1'b1;
            e.data   = d;
            m_mem[mw] = d;
        end else if (match) begin
            e.known = m_known[idx];
            e.data  = m_data[idx];
        end else begin
            e.known = m_mem.exists(mw);
            e.data  = e.known ? m_mem[mw] : 32'h0;
        end
        m_valid[idx] = 1'b1;
        m_tag[idx]   = tg;
        m_data[idx]  = e.data;
        m_known[idx] = e.known;
        if (match) m_hc++; else m_mc++;
        e.hc  = m_hc;
        e.mc  = m_mc;
        e.cyc = cyc;
        address    = a;
        is_write   = w;
        write_data = d;
        sb.push_back(e);
        @(negedge clk);
    endtask

    // ------------------------------------------------------------------
    // Monitor: pops an expectation once its sampling edge has passed
    // ------------------------------------------------------------------
    always @(negedge clk) begin
        if (sb.size() > 0 && sb[0].cyc < cyc) begin
            exp_t e;
            e = sb.pop_front();
            checks++;
            if (hit !== e.hit) begin
                errors++;
                $display("FAIL hit addr=%h got %0b expected %0b", e.addr, hit, e.hit);
            end
            if (e.known) begin
                checks++;
                if (read_data !== e.data) begin
                    errors++;
                    $display("FAIL read_data addr=%h got %h expected %h", e.addr, read_data, e.data);
                end
            end
`ifdef DIRECT_MAPPED_WT_STATS_EN
            checks++;
            if (hit_count !== e.hc || miss_count !== e.mc) begin
                errors++;
                $display("FAIL counters addr=%h got %0d/%0d expected %0d/%0d",
                         e.addr, hit_count, miss_count, e.hc, e.mc);
            end
`endif
        end
    end

    task automatic check_reset_outputs(input string name);
        checks++;
        if (hit !== 1'b0 || read_data !== 32'h0) begin
            errors++;
            $display("FAIL %s got hit=%0b data=%h expected hit=0 data=0", name, hit, read_data);
        end
`ifdef DIRECT_MAPPED_WT_STATS_EN
        checks++;
        if (hit_count !== 32'h0 || miss_count !== 32'h0) begin
            errors++;
            $display("FAIL %s_counters got %0d/%0d expected 0/0", name, hit_count, miss_count);
        end
`endif
    endtask

    function automatic logic [31:0] mk(input logic [19:0] t, input logic [5:0] i);
        return {12'h000, t, i, 2'b00};
    endfunction

    logic [23:0] tag_pool [4];

    initial begin
        tag_pool[0] = 24'h000012;
        tag_pool[1] = 24'h000052;
        tag_pool[2] = 24'h123493;
        tag_pool[3] = 24'hABCDEF;

        reset      = 1'b1;
        address    = 32'h0;
        is_write   = 1'b0;
        write_data = 32'h0;
        model_reset();
        #12;
        check_reset_outputs("reset_state");
        @(negedge clk);               // t = 20: release reset
        reset = 1'b0;

        // Cold miss, then hit on the allocated line
        do_req(32'h0000_0010, 1'b0, 32'h0);
        do_req(32'h0000_0010, 1'b0, 32'h0);

        // Seed the backing word that the BBBBB address aliases to
        do_req(mk(20'h0003B, 6'd5), 1'b1, 32'h5A5A_1234);

        // Fill all lines with AAAAA
        for (int i = 0; i < CS; i++)
            do_req(mk(20'hAAAAA, 6'(i)), 1'b1, 32'h0000_AB00 + 32'(i));
        do_req(mk(20'hAAAAA, 6'd5), 1'b0, 32'h0);

        // Conflict eviction and refill
        do_req(mk(20'hBBBBB, 6'd5), 1'b0, 32'h0);
        do_req(mk(20'hBBBBB, 6'd5), 1'b0, 32'h0);

        // Write-allocate miss, hit, then the evicted tag misses
        do_req(mk(20'hCCCCC, 6'd5), 1'b1, 32'h0000_CC55);
        do_req(mk(20'hCCCCC, 6'd5), 1'b0, 32'h0);
        do_req(mk(20'hBBBBB, 6'd5), 1'b0, 32'h0);

        // Write-through: evict CCCCC, reread from backing memory
        do_req(mk(20'hDDDDD, 6'd5), 1'b0, 32'h0);
        do_req(mk(20'hCCCCC, 6'd5), 1'b0, 32'h0);

        // Unaligned write covers the whole word; read back aligned
        do_req(mk(20'hAAAAA, 6'd9) | 32'h3, 1'b1, 32'hDEAD_BEEF);
        do_req(mk(20'hAAAAA, 6'd9), 1'b0, 32'h0);

        // Randomized traffic over a small tag pool to mix hits and misses
        for (int n = 0; n < 400; n++) begin
            logic [31:0] a;
            a = {tag_pool[$urandom_range(0, 3)], 6'($urandom_range(0, CS - 1)),
                 2'($urandom_range(0, 3))};
            do_req(a, 1'($urandom_range(0, 1)), $urandom);
        end

        // Mid-stream reset: outputs clear immediately, lines invalidated
        #2;
        reset = 1'b1;
        #1;
        check_reset_outputs("async_reset");
        model_reset();
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        do_req(mk(20'hAAAAA, 6'd6), 1'b0, 32'h0);
        do_req(mk(20'hAAAAA, 6'd6), 1'b0, 32'h0);

        // Drain the scoreboard with a bounded wait
        for (int k = 0; k < 10 && sb.size() > 0; k++) @(negedge clk);
        #1;
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain got %0d pending expected 0", sb.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/direct_mapped_wt_cache.md
Name: direct_mapped_wt_cache

Overview:
- Direct-mapped, write-through, write-allocate data cache with one 32-bit word per line.
- Includes an internal word-addressed backing memory that stands in for main memory.
- Serves one request (read or write) per clock and reports hit/miss plus read data one cycle later.
- Used as a standalone cache model in memory-hierarchy experiments.

Parameters:
- CACHE_SIZE, 64, number of lines; power of two, ≥2; INDEX_W = log2(CACHE_SIZE).
- WRITING, "write_through", write policy string; only "write_through" is legal, any other value raises an elaboration-time $error.
- MEM_DEPTH, 4096, backing-memory words; power of two; MEM_W = log2(MEM_DEPTH).

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- address  input  32  byte address of request; sampled every rising edge
- is_write  input  1  1 = write request, 0 = read request
- write_data  input  32  data for write requests; ignored on reads
- hit  output  1  registered; 1 if the request sampled at the last edge hit
- read_data  output  32  registered; data word for the request sampled at the last edge

Behaviour:
- Address split: offset = address[1:0] (ignored, word access only); index = address[2+INDEX_W-1:2]; tag = address[31:2+INDEX_W] (24 bits at default).
- Per line: valid bit, tag, 32-bit data.
- Backing memory word = address[MEM_W+1:2]. Aliasing above MEM_DEPTH is accepted. Not reset; contents undefined until written.
- Request at every rising edge; there is no request-valid signal. Latency is 1 cycle: hit/read_data update at the same edge that samples the request.
- Lookup is combinational from address: match = valid[index] && tag_arr[index] == tag.
- Read hit: hit <= 1; read_data <= line data; no state change.
- Read miss: hit <= 0; read_data <= backing word; line allocated (valid=1, tag, data = backing word). The old line is discarded; no write-back is needed under write-through.
- Write (hit or miss): hit <= match; backing word <= write_data; line <= {valid=1, tag, write_data}; read_data <= write_data.
- Back-to-back same-index requests: the second request sees the state written by the first, so a read immediately after a write to the same address hits.
- Reset (async assert, any time): all valid bits = 0, hit = 0, read_data = 0. Tag and data arrays and the backing memory are not cleared.
- Reset mid-stream: a request sampled while reset is high is dropped; the first edge after deassertion processes a request normally.
- Writes with address bits [1:0] ≠ 0 write the whole word.

Optional Feature:
- Macro DIRECT_MAPPED_WT_STATS_EN.
- Defined: adds two outputs, hit_count (32) and miss_count (32). Each request sampled outside reset increments exactly one of them. Both clear on reset and wrap modulo 2^32.
- Undefined: neither port nor counter logic exists.

Decomposition:
- Package cache_pkg holds:
  - ADDR_W=32, DATA_W=32, OFFSET_W=2.
  - A typedef for the line record {valid, tag, data}.
  - A function deriving TAG_W from INDEX_W.
- One sub-module: wt_backing_mem, a synchronous-write, asynchronous-read word memory (MEM_DEPTH x 32) used for miss fill and write-through.

Test Plan:
- Reset 20 ns, then read 0x0000_0010 → hit=0 (all lines invalid); the next cycle's read of the same address gives hit=1.
- Write 64 lines, addr = {20'hAAAAA, i[5:0], 2'b00}, data = 0xAB00+i → each hit=0; then read {20'hAAAAA, 6'd5, 2'b00} → hit=1, read_data=0x0000AB05.
- Read {20'hBBBBB, 6'd5, 2'b00} → hit=0 (conflict eviction); repeat the read → hit=1, read_data equals the value fetched on the miss.
- Write {20'hCCCCC, 6'd5, 2'b00}=0xCC55 → hit=0, read_data=0xCC55; read the same address → hit=1, read_data=0xCC55; read the BBBBB address → hit=0.
- Write-through check: after the CCCCC write, evict index 5 with another tag, then reread CCCCC → hit=0, read_data=0x0000CC55 from backing memory.
- Assert reset mid-stream → hit=0 and read_data=0 immediately; rereading {20'hAAAAA, 6'd6, 2'b00} → hit=0, read_data=0x0000AB06. With DIRECT_MAPPED_WT_STATS_EN defined, counters read 0 after reset.
